// File: rtl/fg_dilator.sv
// Binary dilation with a (2R+1)x(2R+1) square structuring element on a raster
// foreground stream; emits the dilated mask with explicit output coordinates.
module fg_dilator #(
    parameter int unsigned H_IMG_RES = 640,
    parameter int unsigned V_IMG_RES = 480,
    parameter int unsigned RADIUS    = 2
) (
    input  logic        app_clk,
    input  logic        app_rst,
    input  logic [10:0] hpos,
    input  logic [10:0] vpos,
    input  logic        in_pix,
    input  logic        bypass,
    output logic        out_pix,
    output logic        out_valid,
    output logic [10:0] out_hpos,
    output logic [10:0] out_vpos
);

    localparam int unsigned NB = 2 * RADIUS;
    localparam int unsigned W  = NB + 1;
    localparam int unsigned AW = (H_IMG_RES > 1) ? $clog2(H_IMG_RES) : 1;

    localparam logic [10:0] H_L = 11'(H_IMG_RES);
    localparam logic [10:0] V_L = 11'(V_IMG_RES);
    localparam logic [10:0] R_L = 11'(RADIUS);

    // Line buffers: lbuf[k] holds row vpos-1-k at column hpos; never reset.
    logic lbuf [NB][H_IMG_RES];

    logic [AW-1:0] addr;
    logic          h_act;
    logic          v_wr;
    logic          cur;
    logic [W-1:0]  raw;
    logic [W-1:0]  masked;
    logic          col;
    logic          ctr;
    logic [W-1:0]  win;
    logic [W-1:0]  cwin;
    logic [NB-1:0] hreg;
    logic [NB-1:0] chist;
    logic          sync;
    logic          synced_c;
    logic          in_range;
    logic          valid_c;

    assign addr  = hpos[AW-1:0];
    assign h_act = (hpos < H_L);
    assign v_wr  = (vpos < V_L + R_L);
    assign cur   = (vpos < V_L) ? in_pix : 1'b0;

    // Gather the vertical column and drop rows that fall outside the image.
    always_comb begin
        raw    = '0;
        masked = '0;
        raw[0] = cur;
        for (int k = 1; k < int'(W); k++) begin
            raw[k] = h_act ? lbuf[k-1][addr] : 1'b0;
        end
        for (int k = 0; k < int'(W); k++) begin
            masked[k] = raw[k] & (vpos >= 11'(k)) & (vpos < V_L + 11'(k));
        end
    end

    assign col = h_act & (|masked);
    assign ctr = h_act & masked[RADIUS];

    // Left history is dropped at the start of each line.
    assign win  = (hpos == '0) ? {{NB{1'b0}}, col} : {hreg, col};
    assign cwin = (hpos == '0) ? {{NB{1'b0}}, ctr} : {chist, ctr};

    assign synced_c = sync | ((hpos == '0) && (vpos == '0));
    assign in_range = (hpos >= R_L) && (hpos < H_L + R_L) &&
                      (vpos >= R_L) && (vpos < V_L + R_L);
    assign valid_c  = in_range & synced_c;

    always_ff @(posedge app_clk) begin
        if (h_act && v_wr) begin
            lbuf[0][addr] <= cur;
            for (int k = 1; k < int'(NB); k++) begin
                lbuf[k][addr] <= lbuf[k-1][addr];
            end
        end
    end

    always_ff @(posedge app_clk or posedge app_rst) begin
        if (app_rst) begin
            hreg      <= '0;
            chist     <= '0;
            sync      <= 1'b0;
            out_pix   <= 1'b0;
            out_valid <= 1'b0;
            out_hpos  <= '0;
            out_vpos  <= '0;
        end else begin
            hreg      <= win[NB-1:0];
            chist     <= cwin[NB-1:0];
            sync      <= synced_c;
            out_valid <= valid_c;
            out_pix   <= valid_c & (bypass ? cwin[RADIUS] : (|win));
            if (valid_c) begin
                out_hpos <= hpos - R_L;
                out_vpos <= vpos - R_L;
            end
        end
    end

endmodule
